// File: rtl/mem_pkg.sv
// Shared definitions for the mem_master controller, its memory and its bench:
// FSM state encoding, command op encoding and default geometry.
package mem_pkg;

  // Default geometry: 16-entry address space, 9 implemented words.
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_DEPTH  = 9;

  // Command op encoding carried on req_write.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RD_WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/mem_master_if.sv
// Request/response channels plus the memory strobe bus of mem_master.
// master: the controller's view. slave: the client + memory side.
interface mem_master_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // Single-port synchronous memory
  logic              mem_cs;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_wr, mem_rd, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_wr, mem_rd, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_master.sv
// Initiator-side controller for the single-port synchronous memory.
// Takes one command at a time, sequences cs/wr/rd with the memory's
// registered-read timing and returns data/error on the response channel.
// Optional build macro MEM_MASTER_RDBACK_EN: every in-range write is read
// back and compared; a mismatch is reported on resp_err.
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_master_if.master bus
);

  // DEPTH may equal 2**ADDR_W, so compare with one extra bit.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
`ifdef MEM_MASTER_RDBACK_EN
  logic              cmd_write;
`endif

  // The captured command drives the memory address/data directly, so they
  // hold the last command while idle.
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;

  // Command FSM; every output is registered and set on the transition into
  // the state that owns it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
`ifdef MEM_MASTER_RDBACK_EN
      cmd_write      <= 1'b0;
`endif
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_cs     <= 1'b0;
      bus.mem_wr     <= 1'b0;
      bus.mem_rd     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cmd_addr      <= bus.req_addr;
            cmd_wdata     <= bus.req_wdata;
`ifdef MEM_MASTER_RDBACK_EN
            cmd_write     <= bus.req_write;
`endif
            bus.req_ready <= 1'b0;
            if ({1'b0, bus.req_addr} >= DEPTH_L) begin
              // Out of range: answer immediately, never touch the memory.
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_write == OP_WRITE) begin
              state      <= WRITE;
              bus.mem_cs <= 1'b1;
              bus.mem_wr <= 1'b1;
            end else begin
              state      <= READ;
              bus.mem_cs <= 1'b1;
              bus.mem_rd <= 1'b1;
            end
          end
        end

        WRITE: begin
`ifdef MEM_MASTER_RDBACK_EN
          // Keep cs high and turn the write into a read of the same word.
          state      <= READ;
          bus.mem_wr <= 1'b0;
          bus.mem_rd <= 1'b1;
`else
          state          <= RESP;
          bus.mem_cs     <= 1'b0;
          bus.mem_wr     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
`endif
        end

        READ: begin
          // Memory registers its output at this closing edge.
          state      <= RD_WAIT;
          bus.mem_cs <= 1'b0;
          bus.mem_rd <= 1'b0;
        end

        RD_WAIT: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= bus.mem_rdata;
`ifdef MEM_MASTER_RDBACK_EN
          bus.resp_err   <= cmd_write && (bus.mem_rdata != cmd_wdata);
`else
          bus.resp_err   <= 1'b0;
`endif
        end

        RESP: begin
          // req_ready rises only after the handshake edge.
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.mem_cs     <= 1'b0;
          bus.mem_wr     <= 1'b0;
          bus.mem_rd     <= 1'b0;
        end
      endcase
    end
  end

endmodule
